// File: rtl/spi_slave.sv
// SPI mode-0 slave: CLK-domain oversampling of SCLK/SS_N/MOSI, single-entry TX buffer.
// Define SPI_LSB_FIRST_EN for LSB-first TX and RX; default is MSB-first.
module spi_slave #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              SCLK,
  input  logic              SS_N,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_LOAD,
  output logic              TX_READY,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              TX_UNDERRUN,
  output logic              BUSY
);

  localparam int unsigned CntW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  typedef enum logic {StIdle, StActive} state_e;

  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic ss_s1_q, ss_s2_q;
  logic mosi_s1_q, mosi_s2_q;
  logic [1:0] ss_vld_q;

  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d, rx_next;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d, tx_next;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic tx_ready_q, tx_ready_d;
  logic rx_valid_q, rx_valid_d;
  logic underrun_q, underrun_d;
  logic pend_q, pend_d;
  logic skip_q, skip_d;
  logic armed_q, armed_d;
  logic transfer, sclk_rise, sclk_fall, tx_bit;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      ss_s1_q   <= 1'b1;
      ss_s2_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      ss_vld_q  <= 2'b00;
    end else begin
      sclk_s1_q <= SCLK;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      ss_s1_q   <= SS_N;
      ss_s2_q   <= ss_s1_q;
      mosi_s1_q <= MOSI;
      mosi_s2_q <= mosi_s1_q;
      ss_vld_q  <= {ss_vld_q[0], 1'b1};
    end
  end

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;

`ifdef SPI_LSB_FIRST_EN
  assign rx_next = {mosi_s2_q, rx_shift_q[DATA_W-1:1]};
  assign tx_next = {1'b0, tx_shift_q[DATA_W-1:1]};
  assign tx_bit  = tx_shift_q[0];
`else
  assign rx_next = {rx_shift_q[DATA_W-2:0], mosi_s2_q};
  assign tx_next = {tx_shift_q[DATA_W-2:0], 1'b0};
  assign tx_bit  = tx_shift_q[DATA_W-1];
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    tx_buf_d   = tx_buf_q;
    rx_data_d  = rx_data_q;
    tx_ready_d = tx_ready_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    pend_d     = pend_q;
    skip_d     = skip_q;
    transfer   = 1'b0;
    // Only trust SS_N high once the synchronizer holds a real pin sample, so a select
    // held low across CLR does not restart reception without a fresh falling edge.
    armed_d    = armed_q | (ss_s2_q & ss_vld_q[1]);

    case (state_q)
      StIdle: begin
        if (!ss_s2_q && armed_q) begin
          state_d    = StActive;
          cnt_d      = '0;
          rx_shift_d = '0;
          skip_d     = 1'b0;
          transfer   = 1'b1;
        end
      end
      StActive: begin
        if (ss_s2_q) begin
          state_d    = StIdle;
          cnt_d      = '0;
          rx_shift_d = '0;
          skip_d     = 1'b0;
          pend_d     = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = rx_next;
          // Underrun is flagged when the starved word actually begins clocking.
          if (cnt_q == '0 && pend_q) begin
            underrun_d = 1'b1;
            pend_d     = 1'b0;
          end
          if (cnt_q == LastCnt) begin
            cnt_d      = '0;
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            transfer   = 1'b1;
            skip_d     = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          // The fall right after completion must keep the freshly loaded first bit.
          if (skip_q) begin
            skip_d = 1'b0;
          end else begin
            tx_shift_d = tx_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (transfer) begin
      tx_shift_d = tx_ready_q ? '0 : tx_buf_q;
      pend_d     = tx_ready_q;
      tx_ready_d = 1'b1;
    end
    // A load on a transfer cycle lands in the buffer after the transfer empties it.
    if (TX_LOAD && (tx_ready_q || transfer)) begin
      tx_buf_d   = TX_DATA;
      tx_ready_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_buf_q   <= '0;
      rx_data_q  <= '0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      pend_q     <= 1'b0;
      skip_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      rx_data_q  <= rx_data_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      pend_q     <= pend_d;
      skip_q     <= skip_d;
      armed_q    <= armed_d;
    end
  end

  assign MISO        = (state_q == StActive) ? tx_bit : 1'b0;
  assign BUSY        = (state_q == StActive);
  assign TX_READY    = tx_ready_q;
  assign RX_DATA     = rx_data_q;
  assign RX_VALID    = rx_valid_q;
  assign TX_UNDERRUN = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Randomized bench for spi_slave: SPI master driver, word-level TX buffer model, RX scoreboard.
`timescale 1ns/1ps
module tb_spi_slave;
  localparam int W    = 8;
  localparam int HALF = 5;

  logic         CLK = 1'b0;
  logic         CLR, SCLK, SS_N, MOSI, TX_LOAD;
  logic         MISO, TX_READY, RX_VALID, TX_UNDERRUN, BUSY;
  logic [W-1:0] TX_DATA, RX_DATA;

  int checks = 0;
  int errors = 0;
  int und_exp = 0;
  int und_seen = 0;

  logic [W-1:0] rx_exp_q[$];
  bit           m_full;
  logic [W-1:0] m_buf, m_last_rx;
  logic [W-1:0] f_mosi[4];
  logic [W-1:0] f_tx[4];
  bit           f_ld[4];

  spi_slave #(.DATA_W(W)) dut (
    .CLK(CLK), .CLR(CLR), .SCLK(SCLK), .SS_N(SS_N), .MOSI(MOSI), .MISO(MISO),
    .TX_DATA(TX_DATA), .TX_LOAD(TX_LOAD), .TX_READY(TX_READY), .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID), .TX_UNDERRUN(TX_UNDERRUN), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Monitor: every RX_VALID pulse must match the oldest word the master sent.
  always @(negedge CLK) begin
    if (TX_UNDERRUN === 1'b1) und_seen++;
    if (RX_VALID === 1'b1) begin
      check("rx_valid_expected", 32'(rx_exp_q.size() != 0), 1);
      if (rx_exp_q.size() != 0) check("rx_data", RX_DATA, rx_exp_q.pop_front());
    end
  end

  function automatic int bit_idx(input int i);
`ifdef SPI_LSB_FIRST_EN
    return i;
`else
    return W - 1 - i;
`endif
  endfunction

  // Reference buffer: a transfer takes the buffered word (or zeros) and empties it.
  task automatic take_buf(output logic [W-1:0] word, output bit empty);
    empty  = !m_full;
    word   = m_full ? m_buf : '0;
    m_full = 1'b0;
  endtask

  task automatic load_tx(input logic [W-1:0] d);
    check("tx_ready_before_load", 32'(TX_READY), 32'(!m_full));
    TX_DATA = d;
    TX_LOAD = 1'b1;
    wait_clk(1);
    TX_LOAD = 1'b0;
    m_full  = 1'b1;
    m_buf   = d;
    check("tx_ready_after_load", 32'(TX_READY), 0);
  endtask

  task automatic send_bits(input int k, input int nb, output logic [W-1:0] got);
    int b;
    got = '0;
    for (int i = 0; i < nb; i++) begin
      b    = bit_idx(i);
      MOSI = f_mosi[k][b];
      if (i == 3 && f_ld[k] && !m_full) begin
        load_tx(f_tx[k]);
        wait_clk(HALF - 1);
      end else begin
        wait_clk(HALF);
      end
      got[b] = MISO;
      SCLK   = 1'b1;
      if (i == nb - 1 && nb == W) begin
        wait_clk(3);
        check("rx_valid_latency", 32'(RX_VALID), 1);
        wait_clk(HALF - 3);
      end else begin
        wait_clk(HALF);
      end
      SCLK = 1'b0;
    end
  endtask

  task automatic frame(input int nwords, input int last_bits);
    logic [W-1:0] cur, got;
    bit           cur_empty;
    int           nb;
    SS_N = 1'b0;
    wait_clk(8);
    take_buf(cur, cur_empty);
    for (int k = 0; k < nwords; k++) begin
      nb = (k == nwords - 1) ? last_bits : W;
      if (nb == W) rx_exp_q.push_back(f_mosi[k]);
      send_bits(k, nb, got);
      if (cur_empty) und_exp++;
      if (nb == W) begin
        check("miso_word", got, cur);
        m_last_rx = f_mosi[k];
        take_buf(cur, cur_empty);
      end
    end
    wait_clk(HALF);
    SS_N = 1'b1;
    wait_clk(2);
    check("busy_hold", 32'(BUSY), 1);
    wait_clk(1);
    check("busy_fall", 32'(BUSY), 0);
    wait_clk(HALF);
    check("rx_data_hold", RX_DATA, m_last_rx);
    check("tx_ready_model", 32'(TX_READY), 32'(!m_full));
    check("underrun_count", und_seen, und_exp);
  endtask

  initial begin
    logic [W-1:0] cur, got;
    bit           cur_empty;
    CLR = 1'b1; SCLK = 1'b0; SS_N = 1'b1; MOSI = 1'b0; TX_LOAD = 1'b0; TX_DATA = '0;
    m_full = 1'b0; m_buf = '0; m_last_rx = '0;
    wait_clk(3);
    check("rst_tx_ready", 32'(TX_READY), 1);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_miso", 32'(MISO), 0);
    check("rst_rx_valid", 32'(RX_VALID), 0);
    check("rst_rx_data", RX_DATA, 0);
    check("rst_underrun", 32'(TX_UNDERRUN), 0);
    CLR = 1'b0;
    wait_clk(4);

    // Single word with a preloaded TX word.
    load_tx(8'hA5);
    f_mosi[0] = 8'h3C; f_ld[0] = 1'b0;
    frame(1, W);

    // Back-to-back words, second TX word loaded during the first.
    load_tx(8'h55);
    f_mosi[0] = 8'h01; f_ld[0] = 1'b1; f_tx[0] = 8'hAA;
    f_mosi[1] = 8'hFE; f_ld[1] = 1'b0;
    frame(2, W);

    // Starved buffer: zeros on MISO, underrun pulse, RX still received.
    f_mosi[0] = 8'hC3; f_ld[0] = 1'b0;
    frame(1, W);

    // Select released after 5 bits: partial word dropped.
    f_mosi[0] = 8'h77; f_ld[0] = 1'b0;
    frame(1, 5);

    // Bit-order probe word.
    load_tx(8'h01);
    f_mosi[0] = 8'h80; f_ld[0] = 1'b0;
    frame(1, W);

    // CLR after 3 bits with select still low; no restart until a fresh select.
    f_mosi[0] = 8'h5A; f_ld[0] = 1'b0;
    SS_N = 1'b0;
    wait_clk(8);
    take_buf(cur, cur_empty);
    send_bits(0, 3, got);
    if (cur_empty) und_exp++;
    CLR = 1'b1;
    wait_clk(1);
    CLR = 1'b0;
    m_full = 1'b0; m_last_rx = '0;
    check("clr_rx_data", RX_DATA, 0);
    check("clr_tx_ready", 32'(TX_READY), 1);
    wait_clk(10);
    check("clr_stay_idle", 32'(BUSY), 0);
    SS_N = 1'b1;
    wait_clk(6);
    f_mosi[0] = 8'h81; f_ld[0] = 1'b0;
    frame(1, W);

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      int nw;
      nw = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) begin
        f_mosi[k] = W'($urandom);
        f_tx[k]   = W'($urandom);
        f_ld[k]   = ($urandom_range(0, 3) != 0);
      end
      if (!m_full && $urandom_range(0, 1) == 1) load_tx(W'($urandom));
      frame(nw, (f == 5) ? $urandom_range(1, W - 1) : W);
    end

    wait_clk(10);
    check("rx_queue_drained", rx_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: DATA_W, default 8, sets word length in bits (legal range 2..32).
REQ-002 Port: CLK  input  1  system clock; all logic on rising edge.
REQ-003 Port: CLR  input  1  synchronous reset, active-high.
REQ-004 Port: SCLK  input  1  SPI serial clock from the master; asynchronous to CLK.
REQ-005 Port: SS_N  input  1  SPI slave select, active-low; asynchronous to CLK.
REQ-006 Port: MOSI  input  1  serial data from the master.
REQ-007 Port: MISO  output  1  serial data to the master; driven 0 while not selected.
REQ-008 Port: TX_DATA  input  DATA_W  next word to transmit.
REQ-009 Port: TX_LOAD  input  1  write strobe for TX_DATA.
REQ-010 Port: TX_READY  output  1  high when the TX buffer is empty.
REQ-011 Port: RX_DATA  output  DATA_W  last complete received word.
REQ-012 Port: RX_VALID  output  1  one-CLK pulse when RX_DATA updates.
REQ-013 Port: TX_UNDERRUN  output  1  one-CLK pulse when a word starts with the TX buffer empty.
REQ-014 Port: BUSY  output  1  high while in ACTIVE.

Function
REQ-015 The block SHALL implement SPI mode 0: CPOL=0, MOSI sampled on SCLK rise, MISO changed on SCLK fall.
REQ-016 SCLK, SS_N and MOSI SHALL each pass through a 2-flop synchronizer; SCLK edges SHALL be detected from the synchronized value against a third registered copy.
REQ-017 Operation SHALL be guaranteed when the SCLK high and low phases are each at least 4 CLK periods.
REQ-018 The FSM SHALL have two states: IDLE (SS_N sync high) and ACTIVE.
REQ-019 IDLE->ACTIVE on SS_N sync low; on that cycle, bit counter=0, TX buffer moved to the TX shift register, first bit driven on MISO.
REQ-020 On each synchronized SCLK rise in ACTIVE, the synchronized MOSI SHALL shift into the RX shift register and the bit counter SHALL increment.
REQ-021 On each synchronized SCLK fall in ACTIVE, MISO SHALL present the next TX bit, except on the fall following word completion.
REQ-022 When the counter reaches DATA_W, RX_DATA SHALL load the assembled word, RX_VALID SHALL pulse for one cycle, the counter SHALL return to 0, and the TX buffer SHALL reload the TX shift register, with its first bit driven on MISO.
REQ-023 RX_VALID SHALL be visible on the third CLK rising edge after the last SCLK rise at the pin.
REQ-024 Back-to-back words within one SS_N low period SHALL be supported with no idle SCLK cycles.
REQ-025 TX_LOAD with TX_READY=1 SHALL capture TX_DATA and clear TX_READY; TX_LOAD with TX_READY=0 SHALL be ignored.
REQ-026 A TX buffer transfer to the shift register SHALL set TX_READY=1.
REQ-027 A transfer with the TX buffer empty SHALL transmit all zeros and pulse TX_UNDERRUN.
REQ-028 TX_LOAD coinciding with a transfer cycle SHALL use the pre-load buffer state for the transfer and capture TX_DATA into the buffer afterwards (TX_READY=0 next cycle).
REQ-029 SS_N sync rising in ACTIVE SHALL go to IDLE in the same cycle, discard the partial word, and produce no RX_VALID; the TX buffer contents SHALL be retained.
REQ-030 SCLK edges while in IDLE SHALL be ignored.
REQ-031 RX_DATA SHALL hold its value until the next completed word.

Reset
REQ-032 CLR=1 at a CLK edge SHALL force IDLE, counter=0, shift registers=0, MISO=0, RX_DATA=0, RX_VALID=0, TX_UNDERRUN=0, BUSY=0, TX_READY=1 (buffer empty), and synchronizers to idle values (SCLK 0, SS_N 1, MOSI 0).
REQ-033 CLR asserted mid-word SHALL abort the word with no RX_VALID; the block SHALL wait for a fresh SS_N falling edge before receiving again.

Configuration
REQ-034 With macro SPI_LSB_FIRST_EN defined, both TX and RX SHALL be LSB-first; without it, both SHALL be MSB-first.

Verification
REQ-035 Load TX_DATA=0xA5; master sends 0x3C MSB-first -> MISO carries 1010_0101, RX_DATA=0x3C, one RX_VALID pulse, TX_READY returns to 1.
REQ-036 Two back-to-back words 0x01, 0xFE in one SS_N window with TX 0x55 then 0xAA loaded in time -> two RX_VALID pulses, MISO carries 0x55 then 0xAA, no TX_UNDERRUN.
REQ-037 SS_N rises after 5 SCLK rises -> no RX_VALID, RX_DATA unchanged, BUSY falls 2-3 CLK after the pin.
REQ-038 Start a word with the TX buffer empty -> TX_UNDERRUN pulse, MISO all zeros, RX still received correctly.
REQ-039 CLR pulse after 3 bits, then a full word 0x81 -> no RX_VALID for the aborted word, RX_DATA=0x81 after the new word.
REQ-040 With SPI_LSB_FIRST_EN defined, TX 0x01 and master sends 0x80 LSB-first -> MISO first bit is 1, RX_DATA=0x80.
